// File: rtl/saph_float_sample_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : saph_float_sample_fifo_if
// Description : Capture and readback handshake bundle of the float sample FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
interface saph_float_sample_fifo_if #(
    parameter int LANES   = 2,
    parameter int FLOAT_W = 32
);
    logic                              in_ready;
    logic [LANES-1:0][FLOAT_W-1:0]     in_data;
    logic                              out_valid;
    logic                              out_ready;
    logic [LANES-1:0][FLOAT_W-1:0]     out_data;

    // master: producer + reader side; slave: the FIFO itself
    modport master (
        output in_ready,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_ready,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data
    );
endinterface
`default_nettype wire

// File: rtl/saph_float_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : saph_float_sample_fifo
// Description : Decimating sampler + circular FIFO for multi-lane float data.
//               Optional macro SAPH_SAMPLE_FIFO_OVF_EN adds a saturating
//               overflow counter output (ovf_count_o).
// Revision    : 1.0 - initial release
// ============================================================================
module saph_float_sample_fifo #(
    parameter int LANES   = 2,
    parameter int DEPTH   = 8,
    parameter int DECIM_W = 8,
    parameter int FLOAT_W = 32
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    input  wire logic                       clear_i,
    input  wire logic [DECIM_W-1:0]         decim_i,
    saph_float_sample_fifo_if.slave         bus,
    output logic [$clog2(DEPTH):0]          level_o,
    output logic                            full_o,
    output logic                            dropped_o
`ifdef SAPH_SAMPLE_FIFO_OVF_EN
    ,
    output logic [15:0]                     ovf_count_o
`endif
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;

    typedef logic [LANES-1:0][FLOAT_W-1:0] sample_t;

    sample_t              mem_q [DEPTH];
    logic [c_PTR_W-1:0]   wp_q, wp_d;
    logic [c_PTR_W-1:0]   rp_q, rp_d;
    logic [c_LVL_W-1:0]   level_q, level_d;
    logic [DECIM_W-1:0]   dc_q, dc_d;
`ifdef SAPH_SAMPLE_FIFO_OVF_EN
    logic [15:0]          ovf_q, ovf_d;
`else
    logic                 dropped_q, dropped_d;
`endif

    logic w_valid;
    logic w_full;
    logic w_pop;
    logic w_capture;
    logic w_push;
    logic w_drop;

    assign w_valid   = (level_q != '0);
    assign w_full    = (level_q == c_LVL_W'(DEPTH));
    assign w_pop     = w_valid & bus.out_ready;
    // >= rather than == so a decim lowered below the running count captures next
    assign w_capture = bus.in_ready & (dc_q >= decim_i);
    assign w_push    = w_capture & (~w_full | w_pop);
    assign w_drop    = w_capture & w_full & ~w_pop;

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        level_d = level_q;
        dc_d    = dc_q;
`ifdef SAPH_SAMPLE_FIFO_OVF_EN
        ovf_d   = ovf_q;
`else
        dropped_d = dropped_q;
`endif
        if (clear_i) begin
            wp_d    = '0;
            rp_d    = '0;
            level_d = '0;
            dc_d    = '0;
`ifdef SAPH_SAMPLE_FIFO_OVF_EN
            ovf_d   = '0;
`else
            dropped_d = 1'b0;
`endif
        end else begin
            if (bus.in_ready) begin
                dc_d = w_capture ? '0 : dc_q + DECIM_W'(1);
            end
            if (w_push) begin
                wp_d = wp_q + c_PTR_W'(1);
            end
            if (w_pop) begin
                rp_d = rp_q + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   level_d = level_q + c_LVL_W'(1);
                2'b01:   level_d = level_q - c_LVL_W'(1);
                default: level_d = level_q;
            endcase
            if (w_drop) begin
`ifdef SAPH_SAMPLE_FIFO_OVF_EN
                if (ovf_q != 16'hFFFF) begin
                    ovf_d = ovf_q + 16'd1;
                end
`else
                dropped_d = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            level_q <= '0;
            dc_q    <= '0;
`ifdef SAPH_SAMPLE_FIFO_OVF_EN
            ovf_q   <= '0;
`else
            dropped_q <= 1'b0;
`endif
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            level_q <= level_d;
            dc_q    <= dc_d;
`ifdef SAPH_SAMPLE_FIFO_OVF_EN
            ovf_q   <= ovf_d;
`else
            dropped_q <= dropped_d;
`endif
        end
    end

    // Storage is deliberately unreset; the head is masked while empty instead
    always_ff @(posedge clk) begin
        if (!clear_i && w_push) begin
            mem_q[wp_q] <= bus.in_data;
        end
    end

    assign bus.out_valid = w_valid;
    assign bus.out_data  = w_valid ? mem_q[rp_q] : '0;
    assign level_o       = level_q;
    assign full_o        = w_full;
`ifdef SAPH_SAMPLE_FIFO_OVF_EN
    assign ovf_count_o   = ovf_q;
    assign dropped_o     = (ovf_q != 16'd0);
`else
    assign dropped_o     = dropped_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_saph_float_sample_fifo.sv
`default_nettype none
// Directed self-checking bench for saph_float_sample_fifo (LANES=2, DEPTH=8).
module tb_saph_float_sample_fifo;

    localparam logic [31:0] F1010 = 32'h3F8147AE;
    localparam logic [31:0] F1135 = 32'h3F9147AE;
    localparam logic [31:0] F1260 = 32'h3FA147AE;
    localparam logic [31:0] F3141 = 32'h40490625;
    localparam logic [31:0] F3142 = 32'h40491687;
    localparam logic [31:0] F3143 = 32'h404926E9;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic [7:0]  decim;
    logic [3:0]  level;
    logic        full;
    logic        dropped;
`ifdef SAPH_SAMPLE_FIFO_OVF_EN
    logic [15:0] ovf_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] q[$];

    saph_float_sample_fifo_if #(.LANES(2), .FLOAT_W(32)) bus ();

    saph_float_sample_fifo #(
        .LANES  (2),
        .DEPTH  (8),
        .DECIM_W(8),
        .FLOAT_W(32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (clear),
        .decim_i    (decim),
        .bus        (bus),
        .level_o    (level),
        .full_o     (full),
        .dropped_o  (dropped)
`ifdef SAPH_SAMPLE_FIFO_OVF_EN
        ,
        .ovf_count_o(ovf_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        clear         = 1'b0;
        decim         = 8'd0;
        bus.in_ready  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #12;
        check("rst_level", 64'(level), 64'd0);
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        check("rst_dropped", 64'(dropped), 64'd0);
        check("rst_data", bus.out_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Three float samples, every strobe captured
        bus.in_ready = 1'b1;
        bus.in_data  = {F3141, F1010};
        tick();
        check("lat_valid", 64'(bus.out_valid), 64'd1);
        check("lat_head", bus.out_data, {F3141, F1010});
        bus.in_data = {F3142, F1135};
        tick();
        bus.in_data = {F3143, F1260};
        tick();
        bus.in_ready = 1'b0;
        check("f3_level", 64'(level), 64'd3);
        check("f3_head", bus.out_data, {F3141, F1010});
        bus.out_ready = 1'b1;
        tick();
        check("pop1_head", bus.out_data, {F3142, F1135});
        tick();
        check("pop2_head", bus.out_data, {F3143, F1260});
        tick();
        check("pop3_level", 64'(level), 64'd0);
        check("pop3_valid", 64'(bus.out_valid), 64'd0);
        check("pop3_data", bus.out_data, 64'd0);
        tick();
        check("empty_pop_level", 64'(level), 64'd0);
        bus.out_ready = 1'b0;

        // Decimation by 4: indices 3, 7, 11 captured
        decim        = 8'd3;
        bus.in_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.in_data = {32'(i + 100), 32'(i)};
            tick();
        end
        bus.in_ready = 1'b0;
        check("dec_level", 64'(level), 64'd3);
        bus.out_ready = 1'b1;
        check("dec_head0", bus.out_data, {32'd103, 32'd3});
        tick();
        check("dec_head1", bus.out_data, {32'd107, 32'd7});
        tick();
        check("dec_head2", bus.out_data, {32'd111, 32'd11});
        tick();
        check("dec_empty", 64'(level), 64'd0);
        bus.out_ready = 1'b0;

        // Overfill: 10 captures into 8 entries
        decim        = 8'd0;
        bus.in_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_data = {32'd0, 32'h200 + 32'(i)};
            tick();
            if (i < 8) q.push_back({32'd0, 32'h200 + 32'(i)});
            if (i == 6) check("full_at7", 64'(full), 64'd0);
            if (i == 7) check("full_at8", 64'(full), 64'd1);
        end
        bus.in_ready = 1'b0;
        check("ovfl_level", 64'(level), 64'd8);
        check("ovfl_full", 64'(full), 64'd1);
        check("ovfl_dropped", 64'(dropped), 64'd1);
        check("ovfl_head", bus.out_data, {32'd0, 32'h200});
`ifdef SAPH_SAMPLE_FIFO_OVF_EN
        check("ovfl_count", 64'(ovf_count), 64'd2);
`endif

        // Full with simultaneous pop: accepted, no further drop
        bus.in_ready  = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_data   = {32'd0, 32'h30A};
        tick();
        void'(q.pop_front());
        q.push_back({32'd0, 32'h30A});
        check("pp_level", 64'(level), 64'd8);
        check("pp_head", bus.out_data, q[0]);
        check("pp_dropped", 64'(dropped), 64'd1);
`ifdef SAPH_SAMPLE_FIFO_OVF_EN
        check("pp_count", 64'(ovf_count), 64'd2);
`endif
        for (int k = 0; k < 20; k++) begin
            bus.in_data = {32'hA5A5_0000 + 32'(k), 32'h400 + 32'(k)};
            check("wrap_head", bus.out_data, q[0]);
            tick();
            void'(q.pop_front());
            q.push_back({32'hA5A5_0000 + 32'(k), 32'h400 + 32'(k)});
        end
        check("wrap_level", 64'(level), 64'd8);
        check("wrap_full", 64'(full), 64'd1);
        check("wrap_head_end", bus.out_data, q[0]);

        // Drain to 5 entries, then clear with capture and pop asserted
        bus.in_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            void'(q.pop_front());
        end
        bus.out_ready = 1'b0;
        check("pre_clr_level", 64'(level), 64'd5);
        check("pre_clr_head", bus.out_data, q[0]);
        clear         = 1'b1;
        bus.in_ready  = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_data   = {32'hDEAD_BEEF, 32'hDEAD_BEEF};
        tick();
        clear         = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_ready = 1'b0;
        check("clr_level", 64'(level), 64'd0);
        check("clr_valid", 64'(bus.out_valid), 64'd0);
        check("clr_dropped", 64'(dropped), 64'd0);
        check("clr_data", bus.out_data, 64'd0);
`ifdef SAPH_SAMPLE_FIFO_OVF_EN
        check("clr_count", 64'(ovf_count), 64'd0);
`endif
        decim        = 8'd2;
        bus.in_ready = 1'b1;
        bus.in_data  = {32'd0, 32'h501};
        tick();
        check("clr_s1_level", 64'(level), 64'd0);
        bus.in_data = {32'd0, 32'h502};
        tick();
        check("clr_s2_level", 64'(level), 64'd0);
        bus.in_data = {32'd0, 32'h503};
        tick();
        bus.in_ready = 1'b0;
        check("clr_s3_level", 64'(level), 64'd1);
        check("clr_s3_head", bus.out_data, {32'd0, 32'h503});

        // Asynchronous reset with 4 entries held
        decim        = 8'd0;
        bus.in_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            bus.in_data = {32'd0, 32'h600 + 32'(k)};
            tick();
        end
        bus.in_ready = 1'b0;
        check("mid_level", 64'(level), 64'd4);
        rst_n = 1'b0;
        #2;
        check("arst_valid", 64'(bus.out_valid), 64'd0);
        check("arst_level", 64'(level), 64'd0);
        @(negedge clk);
        rst_n        = 1'b1;
        bus.in_ready = 1'b1;
        bus.in_data  = {32'h0000_0777, 32'h0000_7777};
        tick();
        bus.in_ready = 1'b0;
        check("post_rst_level", 64'(level), 64'd1);
        check("post_rst_head", bus.out_data, {32'h0000_0777, 32'h0000_7777});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/saph_float_sample_fifo.md
Name: saph_float_sample_fifo

Overview:
- Consumer end of the float incrementer stream.
- Samples the multi-lane `float` vector whenever the producer's `ready` strobe is high, optionally decimated.
- Buffers samples in a circular FIFO and presents them on a valid/ready output handshake to a reader (debug port, readback bus or checker).
- Sits directly downstream of `saph_float_incrementer`. Lane count and lane type match that block.

Parameters:
- LANES, 2, number of `float` lanes per sample.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- DECIM_W, 8, width of the decimation control and counter.

Ports:
- clk  in  1  GPU clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush: empties FIFO, zeroes decimation counter.
- decim  in  DECIM_W  capture one of every decim+1 accepted strobes; 0 means every strobe.
- in_ready  in  1  producer's ready strobe; sample is valid this cycle.
- in_data  in  LANES x float  producer's current values.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  reader accepts head entry.
- out_data  out  LANES x float  head entry.
- level  out  $clog2(DEPTH)+1  current occupancy.
- full  out  1  level == DEPTH.
- dropped  out  1  sticky: a captured sample was lost to full.

Behaviour:
- Reset (async assert, sync release), all values 0:
  - write pointer, read pointer, level, decimation counter
  - out_valid, full, dropped
  - out_data (storage array need not be reset; out_data is forced to 0 while empty)
- Capture qualification:
  - A strobe is `in_ready`=1.
  - Decimation counter `dc` increments on each strobe.
  - A strobe with dc==decim is a capture and reloads dc=0.
  - A strobe with dc!=decim does dc+1 and no capture.
  - decim==0 captures every strobe.
  - decim changed mid-run takes effect on the next strobe. If dc>decim after the change, the next strobe captures and reloads dc=0.
- Write: a capture stores in_data to mem[wp], wp+1 mod DEPTH, in the same cycle.
- Read:
  - `out_valid`=(level!=0).
  - out_data=mem[rp] (registered-array read, combinational head).
  - A pop occurs when out_valid & out_ready; rp+1 mod DEPTH.
- Latency: a capture at edge N is visible on out_data/out_valid after edge N (first cycle after).
- Occupancy: level += capture_accepted - pop. Push and pop in the same cycle leaves level unchanged.
- Full:
  - A capture while full with no simultaneous pop is dropped: no write, pointers unchanged, `dropped` set.
  - A capture while full with a simultaneous pop is accepted (pass-through of space).
- Empty: out_ready while empty is ignored; rp unchanged.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally; full/empty come from level, not pointer compare.
- clear:
  - Has priority over capture and pop in the same cycle: wp=rp=level=dc=0, `dropped` cleared, in_data that cycle discarded.
  - A capture resumes from the next strobe.
- Reset mid-operation: all contents are lost; out_valid drops asynchronously with rst_n.
- No arithmetic on float fields; lanes are stored bit-exact.

Optional Feature:
- Macro: SAPH_SAMPLE_FIFO_OVF_EN.
- Defined:
  - Adds output `ovf_count` [15:0], counting dropped captures; saturates at 16'hFFFF; reset 0.
  - Cleared by `clear`.
  - `dropped` = (ovf_count != 0).
- Undefined: port absent; `dropped` is a plain sticky flop as above.

Test Plan:
- Reset, then 3 strobes, decim=0, in_data={fconst(1.010),fconst(3.141)}, then {1.135,3.142}, {1.260,3.143}, out_ready=0 -> level=3, out_valid=1, out_data={1.010,3.141}; then out_ready=1 for 3 cycles -> pops in order, level=0, out_valid=0.
- decim=3, 12 consecutive strobes carrying sample index 0..11 -> exactly indices 3,7,11 captured; level=3.
- DEPTH=8, 10 strobes, out_ready=0 -> full=1 after 8th, samples 8,9 dropped, dropped=1, head=sample 0; with OVF_EN, ovf_count=2.
- Full FIFO, out_ready=1 with a capture in the same cycle -> level stays 8, new sample accepted, no drop; 20 back-to-back push+pop cycles -> pointers wrap, data order preserved.
- level=5, assert clear with simultaneous in_ready and out_ready -> next cycle level=0, out_valid=0, dropped=0, dc=0; the following strobe with decim=2 is not captured until its 3rd.
- Drop rst_n mid-stream with level=4 -> out_valid=0 and level=0 immediately (before the next edge); after release, the first capture appears as head.
